// File: rtl/sub_arbiter_pkg.sv
// Shared types and constants for the two-requester subtract scheduler.
//   sub_state_t : scheduler FSM states
//   REQ0_ID/REQ1_ID : requester identifiers carried on res_id
//   LAST_RESET : reset value of the round-robin pointer (requester 0 wins the first tie)
package sub_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StOut  = 2'd2
  } sub_state_t;

  localparam logic REQ0_ID    = 1'b0;
  localparam logic REQ1_ID    = 1'b1;
  localparam logic LAST_RESET = REQ1_ID;

endpackage

// File: rtl/sub_arbiter_rr_arb2.sv
// rr_arb2: combinational 2-way round-robin picker.
//   valid0, valid1 : requester valids
//   last           : id granted most recently
//   grant_valid    : some requester is granted
//   grant_id       : granted requester id
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last,
  output logic grant_valid,
  output logic grant_id
);
  import sub_arbiter_pkg::*;

  always_comb begin
    grant_valid = valid0 | valid1;
    grant_id    = REQ0_ID;
    if (valid0 && valid1) begin
      // Tie: the requester not served last time wins.
      grant_id = ~last;
    end else if (valid1) begin
      grant_id = REQ1_ID;
    end
  end

endmodule

// File: rtl/sub_arbiter.sv
// sub_arbiter: round-robin scheduler for a shared WIDTH-bit subtractor.
//   clk, rst                  : clock, synchronous active-high reset
//   reqN_valid/a/b/ready      : requester N operand handshake (N = 0, 1)
//   res_valid/diff/borrow/id  : result port, held until res_ready
//   res_ready                 : consumer accepts the result
//   busy                      : FSM is not idle
module sub_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_diff,
  output logic             res_borrow,
  output logic             res_id,
  input  logic             res_ready,
  output logic             busy
);
  import sub_arbiter_pkg::*;

  sub_state_t       state_q, state_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             id_q, id_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_diff_q, res_diff_d;
  logic             res_borrow_q, res_borrow_d;
  logic             res_id_q, res_id_d;

  logic             grant_valid;
  logic             grant_id;
  logic [WIDTH:0]   sub_full;

  rr_arb2 u_rr_arb2 (
    .valid0      (req0_valid),
    .valid1      (req1_valid),
    .last        (last_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Extra top bit is the borrow: set exactly when a < b.
  assign sub_full = {1'b0, a_q} - {1'b0, b_q};

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    res_valid_d  = res_valid_q;
    res_diff_d   = res_diff_q;
    res_borrow_d = res_borrow_q;
    res_id_d     = res_id_q;
    unique case (state_q)
      StIdle: begin
        if (grant_valid) begin
          a_d     = (grant_id == REQ1_ID) ? req1_a : req0_a;
          b_d     = (grant_id == REQ1_ID) ? req1_b : req0_b;
          id_d    = grant_id;
          last_d  = grant_id;
          state_d = StCalc;
        end
      end
      StCalc: begin
        res_diff_d   = sub_full[WIDTH-1:0];
        res_borrow_d = sub_full[WIDTH];
        res_id_d     = id_q;
        res_valid_d  = 1'b1;
        state_d      = StOut;
      end
      StOut: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_q       <= LAST_RESET;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= REQ0_ID;
      res_valid_q  <= 1'b0;
      res_diff_q   <= '0;
      res_borrow_q <= 1'b0;
      res_id_q     <= REQ0_ID;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      res_valid_q  <= res_valid_d;
      res_diff_q   <= res_diff_d;
      res_borrow_q <= res_borrow_d;
      res_id_q     <= res_id_d;
    end
  end

  assign req0_ready = (state_q == StIdle) && grant_valid && (grant_id == REQ0_ID);
  assign req1_ready = (state_q == StIdle) && grant_valid && (grant_id == REQ1_ID);
  assign res_valid  = res_valid_q;
  assign res_diff   = res_diff_q;
  assign res_borrow = res_borrow_q;
  assign res_id     = res_id_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_sub_arbiter.sv
// Self-checking bench for sub_arbiter: vector table, scoreboard monitor, corner sequences.
module tb_sub_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_ready, req1_ready;
  logic       res_valid;
  logic [7:0] res_diff;
  logic       res_borrow;
  logic       res_id;
  logic       res_ready;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct packed {
    logic [7:0] diff;
    logic       borrow;
    logic       id;
  } exp_t;

  exp_t exp_q[$];
  logic id_log[$];
  int   cyc_log[$];

  typedef struct {
    logic       sel;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       borrow;
  } vec_t;

  vec_t vecs[6];

  sub_arbiter #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_diff   (res_diff),
    .res_borrow (res_borrow),
    .res_id     (res_id),
    .res_ready  (res_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor, sampled mid-cycle.
  logic       hold_prev = 1'b0;
  logic [7:0] diff_prev;
  logic       borrow_prev, id_prev;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("stall_valid", 32'(res_valid), 32'd1);
        chk("stall_diff", 32'(res_diff), 32'(diff_prev));
        chk("stall_borrow", 32'(res_borrow), 32'(borrow_prev));
        chk("stall_id", 32'(res_id), 32'(id_prev));
      end
      if (req0_valid && req0_ready)
        exp_q.push_back('{diff: req0_a - req0_b, borrow: (req0_a < req0_b), id: 1'b0});
      if (req1_valid && req1_ready)
        exp_q.push_back('{diff: req1_a - req1_b, borrow: (req1_a < req1_b), id: 1'b1});
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_diff", 32'(res_diff), 32'(e.diff));
          chk("sb_borrow", 32'(res_borrow), 32'(e.borrow));
          chk("sb_id", 32'(res_id), 32'(e.id));
        end
        id_log.push_back(res_id);
        cyc_log.push_back(cyc);
      end
      hold_prev   = res_valid && !res_ready;
      diff_prev   = res_diff;
      borrow_prev = res_borrow;
      id_prev     = res_id;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated transaction with res_ready high, checking the 2-cycle latency.
  task automatic do_txn(input logic sel, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ediff, input logic eborrow);
    step();
    res_ready = 1'b1;
    if (sel) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b;
    end
    #1;
    chk("txn_ready0", 32'(req0_ready), 32'(!sel));
    chk("txn_ready1", 32'(req1_ready), 32'(sel));
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("txn_calc_busy", 32'(busy), 32'd1);
    chk("txn_calc_valid", 32'(res_valid), 32'd0);
    step();
    chk("txn_res_valid", 32'(res_valid), 32'd1);
    chk("txn_diff", 32'(res_diff), 32'(ediff));
    chk("txn_borrow", 32'(res_borrow), 32'(eborrow));
    chk("txn_id", 32'(res_id), 32'(sel));
    step();
    chk("txn_idle_busy", 32'(busy), 32'd0);
    chk("txn_idle_valid", 32'(res_valid), 32'd0);
  endtask

  initial begin
    vecs[0] = '{sel: 1'b0, a: 8'h50, b: 8'h20, diff: 8'h30, borrow: 1'b0};
    vecs[1] = '{sel: 1'b0, a: 8'h00, b: 8'h01, diff: 8'hFF, borrow: 1'b1};
    vecs[2] = '{sel: 1'b1, a: 8'hA5, b: 8'hA5, diff: 8'h00, borrow: 1'b0};
    vecs[3] = '{sel: 1'b0, a: 8'hFF, b: 8'h00, diff: 8'hFF, borrow: 1'b0};
    vecs[4] = '{sel: 1'b0, a: 8'h10, b: 8'h80, diff: 8'h90, borrow: 1'b1};
    vecs[5] = '{sel: 1'b1, a: 8'h00, b: 8'hFF, diff: 8'h01, borrow: 1'b1};

    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    res_ready = 1'b0;
    step();
    step();
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_diff", 32'(res_diff), 32'd0);
    chk("rst_borrow", 32'(res_borrow), 32'd0);
    chk("rst_id", 32'(res_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_ready1", 32'(req1_ready), 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) do_txn(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].borrow);

    // Tie fairness: last grant was req1, so req0 leads.
    step();
    id_log.delete();
    cyc_log.delete();
    res_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 8'h33; req0_b = 8'h11;
    req1_valid = 1'b1; req1_a = 8'h11; req1_b = 8'h33;
    repeat (18) step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (3) step();
    chk("tie_count", 32'(id_log.size()), 32'd6);
    for (int i = 0; i < id_log.size(); i++) begin
      chk("tie_id", 32'(id_log[i]), 32'(i % 2));
      if (i > 0) chk("tie_spacing", 32'(cyc_log[i] - cyc_log[i-1]), 32'd3);
    end

    // Backpressure with a req1 withdrawal during the stall.
    id_log.delete();
    res_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 8'h44; req0_b = 8'h22;
    step();
    req0_valid = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      req1_valid = (i == 1);
      req1_a = 8'h77; req1_b = 8'h01;
      #1;
      chk("bp_valid", 32'(res_valid), 32'd1);
      chk("bp_diff", 32'(res_diff), 32'h22);
      chk("bp_busy", 32'(busy), 32'd1);
      chk("bp_ready0", 32'(req0_ready), 32'd0);
      chk("bp_ready1", 32'(req1_ready), 32'd0);
      step();
    end
    req1_valid = 1'b0;
    res_ready = 1'b1;
    step();
    chk("bp_release_busy", 32'(busy), 32'd0);
    chk("bp_release_valid", 32'(res_valid), 32'd0);
    repeat (5) step();
    chk("wd_results", 32'(id_log.size()), 32'd1);
    chk("wd_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset during CALC after a req0 grant; the pointer must return to its reset value.
    req0_valid = 1'b1; req0_a = 8'h09; req0_b = 8'h03;
    step();
    req0_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    step();
    chk("mid_rst_no_result", 32'(res_valid), 32'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("post_rst_tie0", 32'(req0_ready), 32'd1);
    chk("post_rst_tie1", 32'(req1_ready), 32'd0);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) step();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sub_arbiter.md
# sub_arbiter

Two-requester scheduler for the shared 8-bit subtract datapath (diff = a − b). It arbitrates between two operand sources with round-robin fairness and feeds the winner's operands to a single subtractor. It returns each difference, a borrow flag and the requester ID through a valid/ready result port. It sits between the top-level I/O capture logic and the subtractor, so one datapath can serve two consumers.

## Interface
- `WIDTH`, default 8: operand and result width in bits.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req0_valid`  in  1  requester 0 has operands.
- `req0_a`, `req0_b`  in  WIDTH  requester 0 minuend and subtrahend.
- `req0_ready`  out  1  requester 0 is accepted this cycle.
- `req1_valid`, `req1_a`, `req1_b`, `req1_ready`: same as requester 0, for requester 1.
- `res_valid`  out  1  result held on the result port.
- `res_diff`  out  WIDTH  (a − b) mod 2^WIDTH.
- `res_borrow`  out  1  1 when a < b (unsigned).
- `res_id`  out  1  requester that produced the result.
- `res_ready`  in  1  consumer accepts the result.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, CALC, OUT.
- IDLE: when either valid is high, grant one requester, register its a, b and id, and go to CALC.
- CALC: register diff and borrow into the result register, set res_valid, and go to OUT. This always takes exactly one cycle.
- OUT: hold all result outputs stable. When res_ready = 1, clear res_valid and go to IDLE.
- Grant rule:
  - Only one valid high: that requester wins.
  - Both valid high: the requester not granted last time wins.
  - Pointer `last` updates to the granted id on every accept.
- `reqk_ready = (state == IDLE) && grant == k`. This is combinational from the valids and `last`; the valid→ready path is permitted.
- Arithmetic: WIDTH-bit unsigned subtract.
  - res_borrow = carry-out inverted, i.e. a < b.
  - No saturation; the difference wraps modulo 2^WIDTH.
- Requesters must hold valid and operands until ready. Withdrawing valid before grant is tolerated: the requester is simply not granted.
- Reset values: state IDLE, `last` = 1 (so requester 0 wins the first tie), res_valid 0, res_diff 0, res_borrow 0, res_id 0, busy 0, both readys 0 unless granted in IDLE.

## Timing
- Accept handshake in cycle t (valid & ready) → state CALC at t+1 → res_valid = 1 at t+2.
- Result latency is 2 cycles from accept.
- If res_ready = 1 at t+2, state is IDLE at t+3 and the next accept can happen at t+3. Peak throughput is 1 result per 3 cycles.
- Result stalls extend OUT indefinitely. res_diff, res_borrow and res_id must not change while res_valid = 1 and res_ready = 0.
- res_ready while res_valid = 0 is ignored.
- Boundary cases:
  - Reset asserted in any state: the in-flight operation is discarded. On the next edge all outputs take their reset values.
  - Both requesters continuously valid: grants alternate strictly 0, 1, 0, 1…
  - A single requester continuously valid is granted on every IDLE cycle, with `last` tracking it. It never waits on an idle partner.

## Structure
- Package `sub_arbiter_pkg`:
  - state enum `sub_state_t` (IDLE, CALC, OUT).
  - ID constants `REQ0_ID` = 0 and `REQ1_ID` = 1.
  - reset value of `last`.
- Sub-module `rr_arb2`: combinational 2-way round-robin picker.
  - Inputs: valids, `last`.
  - Outputs: `grant_valid`, `grant_id`.
  - The `last` register stays in the parent.
- Operand register, subtractor and result register are inline in `sub_arbiter`.

## Test plan
- Reset then single request: req0 a = 0x50, b = 0x20 → req0_ready in the same cycle. Two cycles later res_valid = 1, diff = 0x30, borrow = 0, id = 0.
- Wrap/borrow: a = 0x00, b = 0x01 → diff = 0xFF, borrow = 1. With a = b = 0xA5 → diff = 0x00, borrow = 0.
- Tie fairness: both valid continuously, res_ready tied high, six operations → ids 0, 1, 0, 1, 0, 1, one result every 3 cycles.
- Backpressure: hold res_ready = 0 for 5 cycles after res_valid → outputs stable, both readys 0, busy 1. Then res_ready = 1 → IDLE next cycle.
- Reset mid-operation: assert rst in the CALC cycle → the following cycle shows res_valid 0 and state IDLE. The next tie grants req0.
- Withdrawal: req1 valid for 1 cycle while OUT is stalled, then dropped → no req1 result is ever produced.
